// File: rtl/pic_ctrl_sync_if.sv
// Bus/CPU-side signal bundle for pic_ctrl_sync.
interface pic_ctrl_sync_if #(
  parameter int NUM_IRQ = 8
);
  logic               wr_en;
  logic               rd_en;
  logic               a0;
  logic [7:0]         din;
  logic [7:0]         dout;
  logic [NUM_IRQ-1:0] irq_in;
  logic               inta_n;
  logic               int_out;
  logic [7:0]         vec_out;
  logic               vec_valid;
  logic               init_done;
  logic [7:0]         icw3_word;

  modport master (
    output wr_en, rd_en, a0, din, irq_in, inta_n,
    input  dout, int_out, vec_out, vec_valid, init_done, icw3_word
  );

  modport slave (
    input  wr_en, rd_en, a0, din, irq_in, inta_n,
    output dout, int_out, vec_out, vec_valid, init_done, icw3_word
  );
endinterface

// File: rtl/pic_ctrl_sync.sv
// Clocked 8259-style PIC control: ICW/OCW decode, IRR/ISR/IMR, priority, INTA sequencing.
module pic_ctrl_sync #(
  parameter int                 NUM_IRQ  = 8,
  parameter logic [NUM_IRQ-1:0] MASK_RST = '0
) (
  input logic            clk,
  input logic            rst,
  pic_ctrl_sync_if.slave bus
);
  localparam int unsigned NIRQ    = NUM_IRQ;
  localparam logic [2:0]  LOW_RST = 3'(NUM_IRQ - 1);

  typedef enum logic [2:0] {
    S_WAIT_ICW1 = 3'd0,
    S_ICW2      = 3'd1,
    S_ICW3      = 3'd2,
    S_ICW4      = 3'd3,
    S_READY     = 3'd4
  } init_t;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_ACK1 = 2'd1,
    A_GAP  = 2'd2,
    A_ACK2 = 2'd3
  } ack_t;

  init_t              init_st;
  ack_t               ack_st;
  logic [NUM_IRQ-1:0] irr, isr, imr, irq_prev;
  logic [4:0]         base;
  logic               sngl, ic4, ltim, aeoi, rot_aeoi, rd_isr;
  logic [2:0]         lowest, win;
  logic               spur, inta_prev;
  logic [7:0]         dout_r, vec_r, icw3_r;
  logic               vv_r, int_r;

  // priority scan results
  logic [7:0] pend8, isr8, irr8, imr8;
  logic [2:0] lvl, pend_top, isr_top;
  logic       have_pend, have_isr, first_hit, int_cond;

  // decode / next-state helpers
  logic       icw1, wr_ready, ocw1, ocw2, ocw3;
  logic       inta_fall, inta_rise, ack_start, ack_end;
  logic       eoi_do, lvl_ok, set_prio;
  logic [2:0] eoi_lvl, lowest_n;
  logic [7:0] isr_n, irr_n, edge8, rd_val;

  assign bus.dout      = dout_r;
  assign bus.int_out   = int_r;
  assign bus.vec_out   = vec_r;
  assign bus.vec_valid = vv_r;
  assign bus.init_done = (init_st == S_READY);
  assign bus.icw3_word = icw3_r;

  // walk levels from highest to lowest priority; first hit of pend|isr decides int_out
  always_comb begin
    pend8 = '0;
    pend8[NUM_IRQ-1:0] = irr & ~imr;
    isr8 = '0;
    isr8[NUM_IRQ-1:0] = isr;
    irr8 = '0;
    irr8[NUM_IRQ-1:0] = irr;
    imr8 = '0;
    imr8[NUM_IRQ-1:0] = imr;
    lvl       = '0;
    pend_top  = '0;
    isr_top   = '0;
    have_pend = 1'b0;
    have_isr  = 1'b0;
    first_hit = 1'b0;
    int_cond  = 1'b0;
    for (int unsigned i = 1; i <= NIRQ; i++) begin
      lvl = 3'((32'(lowest) + i) % NIRQ);
      if (!have_pend && pend8[lvl]) begin
        have_pend = 1'b1;
        pend_top  = lvl;
      end
      if (!have_isr && isr8[lvl]) begin
        have_isr = 1'b1;
        isr_top  = lvl;
      end
      if (!first_hit && (pend8[lvl] || isr8[lvl])) begin
        first_hit = 1'b1;
        int_cond  = pend8[lvl] && !isr8[lvl];
      end
    end
  end

  // write decode, INTA edge detect and next values of IRR/ISR/lowest
  always_comb begin
    icw1      = bus.wr_en && !bus.a0 && bus.din[4];
    wr_ready  = bus.wr_en && (init_st == S_READY) && !icw1;
    ocw1      = wr_ready && bus.a0;
    ocw2      = wr_ready && !bus.a0 && (bus.din[4:3] == 2'b00);
    ocw3      = wr_ready && !bus.a0 && (bus.din[4:3] == 2'b01);
    inta_fall = inta_prev && !bus.inta_n;
    inta_rise = !inta_prev && bus.inta_n;
    ack_start = (ack_st == A_IDLE) && inta_fall;
    ack_end   = (ack_st == A_ACK2) && inta_rise;
    lvl_ok    = (32'(bus.din[2:0]) < NIRQ);
    eoi_do    = ocw2 && bus.din[5] && have_isr;
    eoi_lvl   = bus.din[6] ? bus.din[2:0] : isr_top;
    set_prio  = ocw2 && (bus.din[7:5] == 3'b110) && lvl_ok;

    // clear from EOI first, then the acknowledge set, so a same-bit set wins
    isr_n = isr8;
    if (eoi_do) isr_n[eoi_lvl] = 1'b0;
    if (ack_start && have_pend) isr_n[pend_top] = 1'b1;
    if (ack_end && aeoi && !spur) isr_n[win] = 1'b0;

    edge8 = '0;
    edge8[NUM_IRQ-1:0] = bus.irq_in & ~irq_prev;
    irr_n = '0;
    if (ltim) begin
      irr_n[NUM_IRQ-1:0] = bus.irq_in;
    end else begin
      irr_n = irr8 | edge8;
      if (ack_start && have_pend) irr_n[pend_top] = 1'b0;
    end

    lowest_n = lowest;
    if (eoi_do && bus.din[7] && (!bus.din[6] || lvl_ok)) lowest_n = eoi_lvl;
    if (set_prio) lowest_n = bus.din[2:0];
    if (ack_end && aeoi && !spur && rot_aeoi) lowest_n = win;

    rd_val = bus.a0 ? imr8 : (rd_isr ? isr8 : irr8);
  end

  // all architectural state; ICW1 overrides every other update
  always_ff @(posedge clk) begin
    if (rst) begin
      init_st   <= S_WAIT_ICW1;
      ack_st    <= A_IDLE;
      irr       <= '0;
      isr       <= '0;
      imr       <= MASK_RST;
      irq_prev  <= '0;
      base      <= '0;
      sngl      <= 1'b0;
      ic4       <= 1'b0;
      ltim      <= 1'b0;
      aeoi      <= 1'b0;
      rot_aeoi  <= 1'b0;
      rd_isr    <= 1'b0;
      lowest    <= LOW_RST;
      win       <= '0;
      spur      <= 1'b0;
      inta_prev <= 1'b1;
      dout_r    <= '0;
      vec_r     <= '0;
      icw3_r    <= '0;
      vv_r      <= 1'b0;
      int_r     <= 1'b0;
    end else begin
      irq_prev  <= bus.irq_in;
      inta_prev <= bus.inta_n;
      if (icw1) begin
        init_st  <= S_ICW2;
        ic4      <= bus.din[0];
        sngl     <= bus.din[1];
        ltim     <= bus.din[3];
        aeoi     <= 1'b0;
        rot_aeoi <= 1'b0;
        imr      <= MASK_RST;
        irr      <= '0;
        isr      <= '0;
        base     <= '0;
        lowest   <= LOW_RST;
        rd_isr   <= 1'b0;
        ack_st   <= A_IDLE;
        win      <= '0;
        spur     <= 1'b0;
        dout_r   <= '0;
        vec_r    <= '0;
        icw3_r   <= '0;
        vv_r     <= 1'b0;
        int_r    <= 1'b0;
      end else begin
        irr    <= irr_n[NUM_IRQ-1:0];
        isr    <= isr_n[NUM_IRQ-1:0];
        lowest <= lowest_n;
        int_r  <= (init_st == S_READY) && (ack_st == A_IDLE) && int_cond && !ack_start;

        case (init_st)
          S_ICW2: if (bus.wr_en && bus.a0) begin
            base    <= bus.din[7:3];
            init_st <= !sngl ? S_ICW3 : (ic4 ? S_ICW4 : S_READY);
          end
          S_ICW3: if (bus.wr_en && bus.a0) begin
            icw3_r  <= bus.din;
            init_st <= ic4 ? S_ICW4 : S_READY;
          end
          S_ICW4: if (bus.wr_en && bus.a0) begin
            aeoi    <= bus.din[1];
            init_st <= S_READY;
          end
          default: ;
        endcase

        if (ocw1) imr <= bus.din[NUM_IRQ-1:0];
        if (ocw2 && (bus.din[7:5] == 3'b100)) rot_aeoi <= 1'b1;
        if (ocw2 && (bus.din[7:5] == 3'b000)) rot_aeoi <= 1'b0;
        if (ocw3 && bus.din[1]) rd_isr <= bus.din[0];
        if (bus.rd_en) dout_r <= rd_val;

        case (ack_st)
          A_IDLE: if (inta_fall) begin
            ack_st <= A_ACK1;
            win    <= have_pend ? pend_top : 3'd7;
            spur   <= !have_pend;
          end
          A_ACK1: if (inta_rise) ack_st <= A_GAP;
          A_GAP: if (inta_fall) begin
            ack_st <= A_ACK2;
            vec_r  <= {base, win};
            vv_r   <= 1'b1;
          end
          A_ACK2: if (inta_rise) begin
            ack_st <= A_IDLE;
            vv_r   <= 1'b0;
          end
          default: ack_st <= A_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/pic_ctrl_sync.md
# pic_ctrl_sync

Clocked, parametrised successor of the 8259-style PIC control logic. Decodes ICW/OCW writes through an explicit initialisation state machine and holds IRR/ISR/IMR for up to 8 request lines. Provides fixed or rotating priority with nested in-service blocking, and runs a two-pulse INTA acknowledge sequence that delivers the interrupt vector. It sits between the bus interface (write/read strobes, A0, data) and the CPU interrupt pins.

## Interface
- NUM_IRQ, 8, number of request lines (1..8); levels >= NUM_IRQ do not exist and are ignored everywhere.
- MASK_RST, {NUM_IRQ{1'b0}}, IMR value after reset and after ICW1.
- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  one-cycle register write strobe.
- rd_en  in  1  one-cycle register read strobe.
- a0  in  1  address bit for decode.
- din  in  8  write data.
- dout  out  8  read data, registered.
- irq_in  in  NUM_IRQ  interrupt requests, synchronous to clk.
- inta_n  in  1  acknowledge, active-low, synchronous, each pulse >= 1 cycle low.
- int_out  out  1  interrupt request to CPU.
- vec_out  out  8  vector {base[7:3], level[2:0]}.
- vec_valid  out  1  high while the second INTA pulse is low.
- init_done  out  1  high in READY.
- icw3_word  out  8  stored ICW3. Cascade is not implemented.

## Operation
- **Reset / ICW1:**
  - All outputs are 0.
  - IMR = MASK_RST; IRR = ISR = 0; base = 0.
  - SNGL = IC4 = LTIM = AEOI = rotate_aeoi = 0.
  - lowest-priority level = NUM_IRQ-1, so IR0 is highest.
  - Read select = IRR.
- **Init FSM states:** WAIT_ICW1, ICW2, ICW3, ICW4, READY.
  - Reset enters WAIT_ICW1.
  - A write with a0=0 and din[4]=1 is ICW1 in any state. It latches IC4=din[0], SNGL=din[1], LTIM=din[3]. It performs the ICW1 clears listed above, aborts any INTA sequence, and goes to ICW2.
  - ICW2 (a0=1): base=din[7:3]. Next state is ICW3 if SNGL=0, else ICW4 if IC4=1, else READY.
  - ICW3 (a0=1): icw3_word=din. Next state is ICW4 if IC4, else READY.
  - ICW4 (a0=1): AEOI=din[1]. Next state is READY.
  - Any other write outside READY is ignored.
- **READY decode:**
  - a0=1 is OCW1: IMR=din[NUM_IRQ-1:0].
  - a0=0 with din[4:3]=00 is OCW2.
  - a0=0 with din[4:3]=01 is OCW3.
- **OCW2 by R/SL/EOI = din[7:5]:**
  - 001 non-specific EOI: clear the highest-priority set ISR bit.
  - 011 specific EOI: clear ISR[din[2:0]].
  - 101: non-specific EOI, then lowest := the cleared level.
  - 111: specific EOI, then lowest := din[2:0].
  - 110: lowest := din[2:0].
  - 100: rotate_aeoi=1.
  - 000: rotate_aeoi=0.
  - 010: no-op.
  - An EOI with no ISR bit set changes nothing.
- **OCW3:** din[1:0]=10 selects IRR for reads; 11 selects ISR; other values leave the selection unchanged.
- **Read:** rd_en loads dout with IMR if a0=1, else the selected IRR/ISR (zero-extended).
- **IRR:**
  - LTIM=0 (edge mode): a bit is set when irq_in is 1 and its previous sample was 0. It clears on acknowledge.
  - LTIM=1 (level mode): IRR = registered irq_in.
- **Priority:**
  - Order, highest first: lowest+1, lowest+2, ... (mod NUM_IRQ), ending at lowest.
  - pend = IRR & ~IMR.
  - int_out=1 in READY, with the INTA FSM in IDLE, when the highest pend level has strictly higher priority than every set ISR bit.
- **INTA FSM states:** IDLE, ACK1, GAP, ACK2.
  - IDLE→ACK1 on a falling edge of inta_n (sample 0, previous 1):
    - winner w = highest priority pend level, frozen for the sequence.
    - ISR[w] is set; in edge mode IRR[w] is cleared.
    - int_out goes to 0.
    - If pend is empty, the acknowledge is spurious: w=7 and ISR/IRR are not changed.
  - ACK1→GAP on a rising edge of inta_n.
  - GAP→ACK2 on a falling edge: vec_out={base,w[2:0]} and vec_valid=1.
  - ACK2→IDLE on a rising edge: vec_valid=0.
    - If AEOI=1 and the acknowledge was not spurious, ISR[w] is cleared.
    - If rotate_aeoi=1 as well, lowest := w.
  - vec_out holds its value until the next ACK2.
- **Simultaneous events:**
  - An ICW1 write overrides everything.
  - An OCW2 EOI clear and an acknowledge set land in the same cycle: the clear applies first, then the set, so a set of the same bit wins.
  - An edge-mode new edge on w in the same cycle as its acknowledge clear: the clear wins.

## Timing
- irq_in first sampled high at edge t: IRR is set after t, and int_out is high after t+1 (2-cycle latency).
- After the first inta_n low sample: int_out is 0 on the next cycle.
- vec_valid rises on the cycle after the second low sample and falls on the cycle after the rising sample.
- dout is valid on the cycle after rd_en.
- A register write takes effect on the cycle after wr_en.
- A mask or priority change affects int_out one cycle later.

## Test plan
- **Basic acknowledge:** Init sequence ICW1=0x13 (SNGL, IC4), ICW2=0x40, ICW4=0x00, then pulse irq_in[3] → init_done=1, int_out=1. Two INTA pulses → vec_out=0x43 during the second pulse, ISR=0x08. Reading ISR (OCW3=0x0B) returns 0x08.
- **Nesting and EOI:** With ISR[3] set, raise irq_in[5] → int_out stays 0. Raise irq_in[1] → int_out=1, vector 0x41. Non-specific EOI (0x20) clears bit 1 → ISR=0x08.
- **Masking:** OCW1=0x02 with irq_in[1] edge pending → int_out=0, and reading the IRR select shows 0x02. OCW1=0x00 → int_out=1 one cycle later.
- **AEOI with rotation:** ICW4=0x02 and OCW2=0x80. Acknowledge IR2 → ISR=0 after the second pulse, and lowest=2. Simultaneous IR1 and IR3 → IR3 wins.
- **Spurious acknowledge:** INTA pulses with pend=0 → vector 0x47, and ISR unchanged.
- **Reset mid-operation:** rst during ACK2 → vec_valid=0, int_out=0, init_done=0, IMR=MASK_RST on the next cycle. ICW1 issued mid-sequence → FSM back to IDLE and state ICW2.
